// File: rtl/eu_wb_stage_pkg.sv
// eu_wb_stage_pkg: opcode encodings, widths and the writeback entry type
package eu_wb_stage_pkg;
  localparam int DATAWIDTH = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH = 2;
  typedef enum logic [3:0] {
    ADD = 4'd0, ADDI = 4'd1, SUB = 4'd2,
    AND = 4'd3, OR = 4'd4, XOR = 4'd5, NOT = 4'd6,
    SLL = 4'd7, SLLI = 4'd8, SLR = 4'd9, SLRI = 4'd10
  } func_t;
  typedef enum logic [1:0] {CLS_MATH, CLS_GATE, CLS_SHIFT, CLS_ILL} func_cls_e;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} fill_e;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATAWIDTH-1:0] data;
  } wb_entry_t;
  function automatic func_cls_e classify(func_t f);
    return (f inside {ADD, ADDI, SUB}) ? CLS_MATH :
           (f inside {AND, OR, XOR, NOT}) ? CLS_GATE :
           (f inside {SLL, SLLI, SLR, SLRI}) ? CLS_SHIFT : CLS_ILL;
  endfunction
endpackage

// File: rtl/eu_wb_stage_if.sv
// eu_wb_stage_if: register-file write port (valid/ready, address, data)
// master drives valid/addr/data and samples ready; slave is the register file.
interface eu_wb_stage_if;
  import eu_wb_stage_pkg::*;
  logic valid;
  logic ready;
  logic [REG_AW-1:0] addr;
  logic [DATAWIDTH-1:0] data;
  modport master (output valid, addr, data, input ready);
  modport slave (input valid, addr, data, output ready);
endinterface

// File: rtl/eu_wb_stage_wb_fifo2.sv
// wb_fifo2: two-entry in-order buffer of wb_entry_t exposing head and tail
// push_i/din_i write the tail (ignored when full), pop_i removes the head,
// head_o is the oldest entry, tail_o the youngest, full_o/empty_o report fill.
module wb_fifo2
  import eu_wb_stage_pkg::*;
(
  input  logic      clk_i,
  input  logic      arst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o,
  output wb_entry_t tail_o
);
  fill_e state_q, state_d;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic rd_q, rd_d, wr_idx, do_push, do_pop;
  assign do_push = push_i & (state_q != TWO);
  assign do_pop = pop_i & (state_q != EMPTY);
  assign wr_idx = rd_q ^ (state_q == ONE);
  always_comb begin
    state_d = state_q == EMPTY ? (do_push ? ONE : EMPTY) :
              state_q == ONE ? (do_push == do_pop ? ONE : (do_push ? TWO : EMPTY)) :
              (do_pop ? ONE : TWO);
    rd_d = rd_q ^ do_pop;
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= EMPTY;
      rd_q <= 1'b0;
      mem_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_idx] <= din_i;
    end
  end
  assign full_o = state_q == TWO;
  assign empty_o = state_q == EMPTY;
  assign head_o = mem_q[rd_q];
  assign tail_o = mem_q[rd_q ^ (state_q == TWO)];
endmodule

// File: rtl/eu_wb_stage.sv
// eu_wb_stage: selects the eu_merge result by func, buffers it, writes it back
// valid_i/ready_o/func_i/rd_addr_i/res_* form the upstream side, wb is the
// register-file write port, fwd_* expose the youngest buffered result,
// illegal_o pulses for an accepted undefined func, retired_cnt_o counts writes.
module eu_wb_stage
  import eu_wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  func_t                func_i,
  input  logic [REG_AW-1:0]    rd_addr_i,
  input  logic [DATAWIDTH-1:0] res_math,
  input  logic [DATAWIDTH-1:0] res_gate,
  input  logic [DATAWIDTH-1:0] res_shift,
  eu_wb_stage_if.master        wb,
  output logic                 fwd_valid_o,
  output logic [REG_AW-1:0]    fwd_addr_o,
  output logic [DATAWIDTH-1:0] fwd_data_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     retired_cnt_o
);
  func_cls_e cls;
  wb_entry_t din, head, tail;
  logic accept, push, pop, full, empty, illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cls = classify(func_i);
  assign accept = valid_i & ready_o;
  assign push = accept & (cls != CLS_ILL);
  assign pop = wb.valid & wb.ready;
  always_comb begin
    din.rd = rd_addr_i;
    din.data = cls == CLS_MATH ? res_math : cls == CLS_GATE ? res_gate : res_shift;
    illegal_d = accept & (cls == CLS_ILL);
    cnt_d = cnt_q + CNT_W'(pop);
  end
  wb_fifo2 u_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .tail_o  (tail)
  );
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      illegal_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      illegal_q <= illegal_d;
      cnt_q <= cnt_d;
    end
  end
  assign ready_o = ~full;
  assign wb.valid = ~empty;
  assign wb.addr = head.rd;
  assign wb.data = head.data;
  assign fwd_valid_o = ~empty;
  assign fwd_addr_o = tail.rd;
  assign fwd_data_o = tail.data;
  assign illegal_o = illegal_q;
  assign retired_cnt_o = cnt_q;
endmodule
